// File: rtl/tt_um_gwaihirs_alu_sequencer.sv
// Serial-operand ALU sequencer (ADD / INV / SUB / ACC) as a TinyTapeout user module.
// Operands arrive on ui_in, qualified by a synchronised rising edge of uio_in[0].
// Optional WAIT_B watchdog: define SEQ_TIMEOUT_EN to enable it.
module tt_um_gwaihirs_alu_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {IDLE, WAIT_B, EXEC, DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_INV = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] stb_sync, clr_sync;
  logic                   stb_d;
  logic                   stb_s, clr_s, stb_edge;

  logic [7:0] a, b, result, acc;
  logic [1:0] op;
  logic       carry, err;
  logic       load_a, load_b, do_exec, tmo;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic [8:0] wide;

  // bits 7:4 of uio_in carry nothing
  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in[7:4]};

  // Synchronisers and edge history run regardless of ena, so edges seen while frozen are lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_sync <= '0;
      clr_sync <= '0;
      stb_d    <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], uio_in[0]};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], uio_in[3]};
      stb_d    <= stb_s;
    end
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign clr_s    = clr_sync[SYNC_STAGES-1];
  assign stb_edge = stb_s & ~stb_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Watchdog counts cycles spent in WAIT_B; restarts on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (ena) begin
      if (state != WAIT_B)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  // State register; ena=0 freezes the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (ena)
      state <= state_next;
  end

  // Next-state and datapath strobes; clr wins and swallows any coincident edge
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    do_exec    = 1'b0;
    tmo        = 1'b0;
    if (clr_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (stb_edge) begin
          load_a     = 1'b1;
          state_next = uio_in[1] ? EXEC : WAIT_B;  // INV/ACC need no B
        end
        WAIT_B: begin
          if (stb_edge) begin
            load_b     = 1'b1;
            state_next = EXEC;
          end else if (tmo_hit) begin
            tmo        = 1'b1;
            state_next = IDLE;
          end
        end
        EXEC: begin
          do_exec    = 1'b1;
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Operation datapath; borrow of SUB is bit 8 of the 9-bit difference (1 iff a<b)
  always_comb begin
    wide      = 9'd0;
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        alu_res   = wide[7:0];
        alu_carry = wide[8];
      end
      OP_INV: begin
        alu_res   = ~a;
        alu_carry = 1'b0;
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        alu_res   = wide[7:0];
        alu_carry = wide[8];
      end
      OP_ACC: begin
        wide      = {1'b0, acc} + {1'b0, a};
        alu_res   = wide[7:0];
        alu_carry = wide[8];
      end
      default: ;
    endcase
  end

  // Operand, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      op     <= '0;
      result <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else if (ena) begin
      if (clr_s) begin
        result <= '0;
        acc    <= '0;
        carry  <= 1'b0;
        err    <= 1'b0;
      end else begin
        if (load_a) begin
          a  <= ui_in;
          op <= uio_in[2:1];
        end
        if (load_b)
          b <= ui_in;
        if (do_exec) begin
          result <= alu_res;
          carry  <= alu_carry;
          if (op == OP_ACC)
            acc <= alu_res;
        end
        if (tmo)
          err <= 1'b1;
      end
    end
  end

  assign uo_out  = result;
  assign uio_out = {err, carry, state == DONE, (state == WAIT_B) || (state == EXEC), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_gwaihirs_alu_sequencer.sv
// Directed bench for the ALU sequencer with a result/carry scoreboard.
module tb_tt_um_gwaihirs_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       stb = 1'b0, clr = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] uio_in, uio_out, uio_oe, uo_out;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic [7:0] m_acc = 8'h00;
  logic [7:0] held;

  assign uio_in = {4'b0000, clr, op, stb};

  tt_um_gwaihirs_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  // Reference: {carry, result}
  function automatic logic [8:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] ac);
    logic [8:0] r;
    case (o)
      2'b00:   r = {1'b0, x} + {1'b0, y};
      2'b01:   r = {1'b0, ~x};
      2'b10:   r = {(x < y), 8'(x - y)};
      default: r = {1'b0, ac} + {1'b0, x};
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operand strobe: hold >= SYNC_STAGES+2 cycles, then release long enough to re-arm
  task automatic pulse(input logic [7:0] v, input logic [1:0] o);
    @(negedge clk);
    ui_in = v; op = o; stb = 1'b1;
    repeat (4) @(negedge clk);
    stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Bounded wait for done, then pop the scoreboard and compare
  task automatic check_result(input string tag);
    logic [8:0] e;
    int n = 0;
    while (uio_out[5] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {8'h0, uio_out[5]}, 9'h001);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 9'h1, 9'h0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_res"}, {1'b0, uo_out}, {1'b0, e[7:0]});
      chk({tag, "_carry"}, {8'h0, uio_out[6]}, {8'h0, e[8]});
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    repeat (4) @(negedge clk);
    m_acc = 8'h00;
    chk("clr_res", {1'b0, uo_out}, 9'h000);
    chk("clr_flags", {1'b0, uio_out}, 9'h000);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [8:0] r;
    repeat (3) @(negedge clk);
    chk("rst_uo", {1'b0, uo_out}, 9'h000);
    chk("rst_uio", {1'b0, uio_out}, 9'h000);
    chk("rst_oe", {1'b0, uio_oe}, 9'h0F0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD with exact latency after the B edge
    pulse(8'h7F, 2'b00);
    chk("add_waitb_busy", {1'b0, uio_out}, 9'h010);
    exp_q.push_back(model(2'b00, 8'h7F, 8'h81, m_acc));
    @(negedge clk);
    ui_in = 8'h81; stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("add_exec", {7'h0, uio_out[5:4]}, 9'h001);
    @(negedge clk);
    chk("add_lat_done", {7'h0, uio_out[5:4]}, 9'h002);
    stb = 1'b0;
    repeat (3) @(negedge clk);
    check_result("add");

    // INV: single operand, ends idle-done with no busy
    exp_q.push_back(model(2'b01, 8'h5A, 8'h00, m_acc));
    pulse(8'h5A, 2'b01);
    chk("inv_busy", {8'h0, uio_out[4]}, 9'h000);
    check_result("inv");

    // SUB borrow and no-borrow
    pulse(8'h10, 2'b10);
    exp_q.push_back(model(2'b10, 8'h10, 8'h20, m_acc));
    pulse(8'h20, 2'b10);
    check_result("sub1");
    pulse(8'h20, 2'b10);
    exp_q.push_back(model(2'b10, 8'h20, 8'h10, m_acc));
    pulse(8'h10, 2'b10);
    check_result("sub2");

    // ACC twice from cleared accumulator
    do_clr();
    repeat (2) begin
      r = model(2'b11, 8'hF0, 8'h00, m_acc);
      exp_q.push_back(r);
      m_acc = r[7:0];
      pulse(8'hF0, 2'b11);
      check_result("acc");
    end

    // clr while waiting for B, next edge is a fresh A
    pulse(8'h33, 2'b00);
    chk("clr_pre_busy", {8'h0, uio_out[4]}, 9'h001);
    do_clr();
    pulse(8'h01, 2'b00);
    chk("after_clr_busy", {8'h0, uio_out[4]}, 9'h001);
    exp_q.push_back(model(2'b00, 8'h01, 8'h02, m_acc));
    pulse(8'h02, 2'b00);
    check_result("after_clr_add");

    // ena=0: strobe is lost, outputs hold
    ena = 1'b0;
    held = uo_out;
    pulse(8'h0F, 2'b01);
    chk("ena0_hold", {1'b0, uo_out}, {1'b0, held});
    ena = 1'b1;
    repeat (4) @(negedge clk);
    chk("ena1_lost", {1'b0, uo_out}, {1'b0, held});
    chk("ena1_done", {8'h0, uio_out[5]}, 9'h001);

`ifdef SEQ_TIMEOUT_EN
    // A only; watchdog returns to IDLE with err set
    pulse(8'h44, 2'b00);
    repeat (260) @(negedge clk);
    chk("tmo_err", {7'h0, uio_out[7], uio_out[4]}, 9'h002);
    chk("tmo_res", {1'b0, uo_out}, {1'b0, held});
`else
    pulse(8'h44, 2'b00);
    repeat (260) @(negedge clk);
    chk("notmo_wait", {7'h0, uio_out[7], uio_out[4]}, 9'h001);
    do_clr();
`endif

    // Async reset in EXEC clears everything immediately
    @(negedge clk);
    ui_in = 8'h0F; op = 2'b01; stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {8'h0, uio_out[4]}, 9'h001);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_uo", {1'b0, uo_out}, 9'h000);
    chk("rst_mid_uio", {1'b0, uio_out}, 9'h000);
    stb = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
